mem_stage: RTL and testbench

- Memory-access pipeline stage. Sits directly downstream of the execute stage and consumes its outputs: instruction, ALU result, store data and control bits.
- Holds its own input pipeline register and runs a req/ack handshake to data memory.
- Aligns store data and extends load data.
- Produces a registered writeback bundle. Raises mem_busy to freeze upstream stages while memory is outstanding.

---
 rtl/mem_stage.sv | 223 ++++++++++++++++++++++
 tb/tb_mem_stage.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: input capture register, req/ack handshake to data memory,
// store-lane alignment, load extraction/extension and a registered writeback bundle.
// Optional define MEM_ALIGN_CHECK_EN: misaligned word/half accesses are dropped and flagged.
module mem_stage #(
  parameter bit         BIG_ENDIAN = 1'b1,
  parameter logic [1:0] DSIZE_WORD = 2'b00,
  parameter logic [1:0] DSIZE_HALF = 2'b01,
  parameter logic [1:0] DSIZE_BYTE = 2'b10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic [31:0] eInst,
  input  logic        eMemWr,
  input  logic        eMemToReg,
  input  logic        eRegWr,
  input  logic [1:0]  eDsize,
  input  logic        eLoadext,
  input  logic        eJal,
  input  logic [1:0]  eFPoint,
  input  logic [31:0] eALUout,
  input  logic [31:0] eBusB,
  input  logic [4:0]  eRw,
  input  logic [31:0] eDelayslot2,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        mem_busy,
  output logic [31:0] wInst,
  output logic        wRegWr,
  output logic [4:0]  wRw,
  output logic [1:0]  wFPoint,
  output logic [31:0] wData,
  output logic        misalign_err
);

  typedef enum logic [0:0] {StIdle, StWait} memState;

  memState     state;

  logic [31:0] qInst;
  logic        qMemWr;
  logic        qMemToReg;
  logic        qRegWr;
  logic [1:0]  qDsize;
  logic        qLoadext;
  logic        qJal;
  logic [1:0]  qFPoint;
  logic [31:0] qALUout;
  logic [31:0] qBusB;
  logic [4:0]  qRw;
  logic [31:0] qDelayslot2;

  logic        memop;
  logic        misalign;
  logic        isWord;
  logic        isHalf;
  logic [1:0]  alignOff;
  logic [1:0]  byteLane;
  logic        upperHalf;
  logic [7:0]  byteVal;
  logic [15:0] halfVal;
  logic [3:0]  laneBe;
  logic [31:0] laneWdata;
  logic [31:0] loadData;
  logic [31:0] wbData;
  logic        wbCommit;

  // Capture register: frozen while memory is outstanding, bubble on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qInst       <= '0;
      qMemWr      <= 1'b0;
      qMemToReg   <= 1'b0;
      qRegWr      <= 1'b0;
      qDsize      <= '0;
      qLoadext    <= 1'b0;
      qJal        <= 1'b0;
      qFPoint     <= '0;
      qALUout     <= '0;
      qBusB       <= '0;
      qRw         <= '0;
      qDelayslot2 <= '0;
    end else if (!mem_busy) begin
      if (stall) begin
        qInst       <= '0;
        qMemWr      <= 1'b0;
        qMemToReg   <= 1'b0;
        qRegWr      <= 1'b0;
        qDsize      <= '0;
        qLoadext    <= 1'b0;
        qJal        <= 1'b0;
        qFPoint     <= '0;
        qALUout     <= '0;
        qBusB       <= '0;
        qRw         <= '0;
        qDelayslot2 <= '0;
      end else begin
        qInst       <= eInst;
        qMemWr      <= eMemWr;
        qMemToReg   <= eMemToReg;
        qRegWr      <= eRegWr;
        qDsize      <= eDsize;
        qLoadext    <= eLoadext;
        qJal        <= eJal;
        qFPoint     <= eFPoint;
        qALUout     <= eALUout;
        qBusB       <= eBusB;
        qRw         <= eRw;
        qDelayslot2 <= eDelayslot2;
      end
    end
  end

  assign memop = qMemWr | qMemToReg;

  always_comb begin
    isWord = 1'b0;
    isHalf = 1'b0;
    case (qDsize)
      DSIZE_WORD: isWord = 1'b1;
      DSIZE_HALF: isHalf = 1'b1;
      DSIZE_BYTE: ;
      default:    ;
    endcase
  end

  // Low address bits are masked to natural alignment before lane selection.
  always_comb begin
    alignOff  = isWord ? 2'b00 : (isHalf ? {qALUout[1], 1'b0} : qALUout[1:0]);
    byteLane  = BIG_ENDIAN ? ~alignOff : alignOff;
    upperHalf = alignOff[1] ^ BIG_ENDIAN;
    byteVal   = 8'(dmem_rdata >> {byteLane, 3'b000});
    halfVal   = upperHalf ? dmem_rdata[31:16] : dmem_rdata[15:0];
    if (isWord) begin
      laneBe    = 4'b1111;
      laneWdata = qBusB;
      loadData  = dmem_rdata;
    end else if (isHalf) begin
      laneBe    = upperHalf ? 4'b1100 : 4'b0011;
      laneWdata = {2{qBusB[15:0]}};
      loadData  = {{16{qLoadext & halfVal[15]}}, halfVal};
    end else begin
      laneBe    = 4'b0001 << byteLane;
      laneWdata = {4{qBusB[7:0]}};
      loadData  = {{24{qLoadext & byteVal[7]}}, byteVal};
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = memop & ((isWord & (|qALUout[1:0])) | (isHalf & qALUout[0]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= misalign;
    end
  end
`else
  assign misalign     = 1'b0;
  assign misalign_err = 1'b0;
`endif

  assign dmem_req   = (state == StWait) | (memop & ~misalign);
  assign dmem_we    = qMemWr;
  assign dmem_addr  = {qALUout[31:2], 2'b00};
  assign dmem_be    = laneBe;
  assign dmem_wdata = laneWdata;
  assign mem_busy   = dmem_req & ~dmem_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= StIdle;
    end else begin
      case (state)
        StIdle:  if (mem_busy) state <= StWait;
        StWait:  if (dmem_ack) state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

  always_comb begin
    if (qJal) begin
      wbData = qDelayslot2;
    end else if (qMemToReg) begin
      wbData = loadData;
    end else begin
      wbData = qALUout;
    end
  end

  // A dropped (misaligned) or still-waiting access commits a bubble.
  assign wbCommit = ~mem_busy & ~misalign;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wInst   <= '0;
      wRegWr  <= 1'b0;
      wRw     <= '0;
      wFPoint <= '0;
      wData   <= '0;
    end else if (wbCommit) begin
      wInst   <= qInst;
      wRegWr  <= qRegWr;
      wRw     <= qRw;
      wFPoint <= qFPoint;
      wData   <= wbData;
    end else begin
      wInst   <= '0;
      wRegWr  <= 1'b0;
      wRw     <= '0;
      wFPoint <= '0;
      wData   <= '0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: byte-addressed reference model checked every cycle, directed vectors
// with hand-computed pins, and a programmable-latency memory responder.
module tb_mem_stage;

  localparam bit BIG = 1'b1;
`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] inst;
    logic        memWr;
    logic        memToReg;
    logic        regWr;
    logic [1:0]  dsize;
    logic        loadext;
    logic        jal;
    logic [1:0]  fpoint;
    logic [31:0] alu;
    logic [31:0] busB;
    logic [4:0]  rw;
    logic [31:0] ds2;
  } instr_t;

  typedef struct {
    instr_t      v;
    logic [31:0] rd;
    int          dly;
  } vecRec;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  instr_t      drv = '0;
  logic [31:0] memRdata = '0;
  int          ackDelay = 0;
  int          waitCnt;

  logic        dmem_req, dmem_we, dmem_ack, mem_busy, wRegWr, misalign_err;
  logic [31:0] dmem_addr, dmem_wdata, wInst, wData;
  logic [3:0]  dmem_be;
  logic [4:0]  wRw;
  logic [1:0]  wFPoint;

  int nVec = 0;
  int nMis = 0;

  mem_stage #(.BIG_ENDIAN(BIG)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .eInst(drv.inst), .eMemWr(drv.memWr), .eMemToReg(drv.memToReg), .eRegWr(drv.regWr),
    .eDsize(drv.dsize), .eLoadext(drv.loadext), .eJal(drv.jal), .eFPoint(drv.fpoint),
    .eALUout(drv.alu), .eBusB(drv.busB), .eRw(drv.rw), .eDelayslot2(drv.ds2),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_rdata(memRdata), .dmem_ack(dmem_ack),
    .mem_busy(mem_busy), .wInst(wInst), .wRegWr(wRegWr), .wRw(wRw), .wFPoint(wFPoint),
    .wData(wData), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  // Memory answers after ackDelay wait cycles of an outstanding request.
  assign dmem_ack = dmem_req && (waitCnt == ackDelay);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) waitCnt <= 0;
    else if (dmem_req && !dmem_ack) waitCnt <= waitCnt + 1;
    else waitCnt <= 0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sizeOf(input logic [1:0] ds);
    if (ds == 2'b00) return 4;
    if (ds == 2'b01) return 2;
    return 1;
  endfunction

  function automatic int offOf(input instr_t v);
    int s = sizeOf(v.dsize);
    int a = int'(v.alu[1:0]);
    return (a / s) * s;
  endfunction

  function automatic int laneOf(input int a);
    return BIG ? 3 - a : a;
  endfunction

  function automatic logic [3:0] beOf(input instr_t v);
    logic [3:0] be = '0;
    int s = sizeOf(v.dsize);
    int o = offOf(v);
    for (int k = 0; k < s; k++) be[laneOf(o + k)] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] wdataOf(input instr_t v);
    logic [31:0] w = '0;
    int s = sizeOf(v.dsize);
    for (int j = 0; j < 4; j++) w[8*j +: 8] = v.busB[8*(j % s) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] loadOf(input instr_t v, input logic [31:0] rd);
    logic [31:0] val = '0;
    logic [7:0]  b;
    int s = sizeOf(v.dsize);
    int o = offOf(v);
    for (int k = 0; k < s; k++) begin
      b = rd[8*laneOf(o + k) +: 8];
      if (BIG) val = (val << 8) | {24'h0, b};
      else     val = val | ({24'h0, b} << (8 * k));
    end
    if (v.loadext && s < 4 && val[8*s-1]) val = val | ~((32'h1 << (8 * s)) - 32'h1);
    return val;
  endfunction

  function automatic logic misOf(input instr_t v);
    int s = sizeOf(v.dsize);
    return (int'(v.alu[1:0]) % s) != 0;
  endfunction

  function automatic instr_t mkLoad(input logic [1:0] ds, input logic ext,
                                    input logic [31:0] addr, input logic [4:0] rw);
    instr_t v = '0;
    v.inst = {6'h23, 5'd0, rw, addr[15:0]};
    v.memToReg = 1'b1;
    v.regWr = 1'b1;
    v.dsize = ds;
    v.loadext = ext;
    v.alu = addr;
    v.rw = rw;
    return v;
  endfunction

  function automatic instr_t mkStore(input logic [1:0] ds, input logic [31:0] addr,
                                     input logic [31:0] data);
    instr_t v = '0;
    v.inst = {6'h2B, 5'd0, 5'd0, addr[15:0]};
    v.memWr = 1'b1;
    v.dsize = ds;
    v.alu = addr;
    v.busB = data;
    return v;
  endfunction

  function automatic instr_t mkAlu(input logic [31:0] res, input logic [4:0] rw,
                                   input logic [1:0] fp);
    instr_t v = '0;
    v.inst = {6'h00, 5'd1, 5'd2, rw, 11'h020};
    v.regWr = 1'b1;
    v.alu = res;
    v.rw = rw;
    v.fpoint = fp;
    return v;
  endfunction

  // Reference model: what sits in the stage, and what writeback must show.
  instr_t      cur;
  int          curWaits;
  logic        mValid, mRegWr, mMis;
  logic [31:0] mInst, mData;
  logic [4:0]  mRw;
  logic [1:0]  mFPoint;

  always @(negedge clk) begin : compare
    logic memop, mis, expReq, ackNow;
    if (!rst_n) begin
      cur = '0; curWaits = 0; mValid = 1'b0; mRegWr = 1'b0; mMis = 1'b0;
      mInst = '0; mData = '0; mRw = '0; mFPoint = '0;
    end
    memop  = cur.memWr | cur.memToReg;
    mis    = ALIGN_CHK && memop && misOf(cur);
    expReq = memop && !mis;
    ackNow = expReq && (curWaits == ackDelay);
    chk("dmem_req", 32'(dmem_req), 32'(expReq));
    chk("mem_busy", 32'(mem_busy), 32'(expReq && !ackNow));
    if (expReq) begin
      chk("dmem_addr", dmem_addr, cur.alu & ~32'h3);
      chk("dmem_be", 32'(dmem_be), 32'(beOf(cur)));
      chk("dmem_we", 32'(dmem_we), 32'(cur.memWr));
      if (cur.memWr) chk("dmem_wdata", dmem_wdata, wdataOf(cur));
    end
    chk("wRegWr", 32'(wRegWr), 32'(mRegWr));
    chk("wInst", wInst, mInst);
    chk("misalign_err", 32'(misalign_err), 32'(mMis));
    if (mValid) begin
      chk("wRw", 32'(wRw), 32'(mRw));
      chk("wFPoint", 32'(wFPoint), 32'(mFPoint));
      chk("wData", wData, mData);
    end
    if (rst_n) begin
      if (expReq && !ackNow) begin
        mValid = 1'b0; mRegWr = 1'b0; mInst = '0; mMis = 1'b0;
        curWaits++;
      end else begin
        mMis = mis;
        if (mis) begin
          mValid = 1'b0; mRegWr = 1'b0; mInst = '0;
        end else begin
          mValid = 1'b1; mRegWr = cur.regWr; mInst = cur.inst;
          mRw = cur.rw; mFPoint = cur.fpoint;
          mData = cur.jal ? cur.ds2 : (cur.memToReg ? loadOf(cur, memRdata) : cur.alu);
        end
        cur = stall ? '0 : drv;
        curWaits = 0;
      end
    end
  end

  // Present one instruction, then bubbles until the stage releases it.
  task automatic run(input instr_t v, input logic [31:0] rd, input int dly, output int busyCyc,
                     output logic firstReq, output logic [31:0] firstAddr,
                     output logic [3:0] firstBe, output logic [31:0] firstWdata);
    @(posedge clk); #1;
    drv = v; memRdata = rd; ackDelay = dly;
    @(posedge clk); #1;
    drv = '0;
    @(negedge clk);
    firstReq = dmem_req; firstAddr = dmem_addr; firstBe = dmem_be; firstWdata = dmem_wdata;
    busyCyc = 0;
    while (mem_busy) begin
      busyCyc++;
      if (busyCyc > 40) begin
        nVec++; nMis++;
        $display("FAIL ack_timeout: mem_busy=%0d after %0d cycles, want 0", mem_busy, busyCyc);
        break;
      end
      @(negedge clk);
    end
  endtask

  int          bc;
  logic        fr;
  logic [31:0] fa, fw;
  logic [3:0]  fb;
  vecRec       tbl[$];
  instr_t      t;

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_wRegWr", 32'(wRegWr), 32'h0);
    chk("rst_wData", wData, 32'h0);

    // Signed byte load at the least significant big-endian lane, zero-wait.
    run(mkLoad(2'b10, 1'b1, 32'h103, 5'd4), 32'h112233F4, 0, bc, fr, fa, fb, fw);
    chk("lb_req", 32'(fr), 32'h1);
    chk("lb_busy", 32'(bc), 32'h0);
    @(negedge clk);
    chk("lb_wData", wData, 32'hFFFFFFF4);
    chk("lb_wRegWr", 32'(wRegWr), 32'h1);

    run(mkStore(2'b01, 32'h202, 32'h1234ABCD), 32'h0, 3, bc, fr, fa, fb, fw);
    chk("sh_busy_cycles", 32'(bc), 32'd3);
    chk("sh_be", 32'(fb), 32'h3);
    chk("sh_wdata", fw, 32'hABCDABCD);
    chk("sh_addr", fa, 32'h200);
    @(negedge clk);

    t = mkAlu(32'h1234, 5'd31, 2'b00);
    t.jal = 1'b1;
    t.ds2 = 32'h40;
    run(t, 32'h0, 0, bc, fr, fa, fb, fw);
    chk("jal_req", 32'(fr), 32'h0);
    @(negedge clk);
    chk("jal_wData", wData, 32'h40);
    chk("jal_wRw", 32'(wRw), 32'd31);

    run(mkLoad(2'b01, 1'b0, 32'h102, 5'd5), 32'h12348765, 1, bc, fr, fa, fb, fw);
    @(negedge clk);
    chk("lhu_wData", wData, 32'h00008765);

    run(mkStore(2'b10, 32'h301, 32'h00000055), 32'h0, 0, bc, fr, fa, fb, fw);
    chk("sb_be", 32'(fb), 32'h4);
    chk("sb_wdata", fw, 32'h55555555);
    @(negedge clk);

    // Stalled ADD becomes a bubble; the same ADD unstalled commits.
    @(posedge clk); #1;
    drv = mkAlu(32'd7, 5'd3, 2'b00); stall = 1'b1;
    @(posedge clk); #1;
    stall = 1'b0;
    @(posedge clk); #1;
    drv = '0;
    @(negedge clk);
    chk("stall_bubble", 32'(wRegWr), 32'h0);
    @(negedge clk);
    chk("add_wData", wData, 32'd7);
    chk("add_wRegWr", 32'(wRegWr), 32'h1);

    // Stall raised while memory is outstanding must not disturb the held access.
    @(posedge clk); #1;
    drv = mkStore(2'b00, 32'h500, 32'h12345678); ackDelay = 2;
    @(posedge clk); #1;
    drv = mkAlu(32'h99, 5'd6, 2'b01); stall = 1'b1;
    repeat (2) @(posedge clk);
    #1 stall = 1'b0;
    @(posedge clk); #1;
    drv = '0;
    repeat (3) @(negedge clk);

    // Back-to-back zero-wait loads.
    @(posedge clk); #1;
    drv = mkLoad(2'b00, 1'b0, 32'h208, 5'd7); memRdata = 32'hA5A5_0F0F; ackDelay = 0;
    @(posedge clk); #1;
    drv = mkLoad(2'b10, 1'b1, 32'h209, 5'd8);
    @(posedge clk); #1;
    drv = '0;
    repeat (3) @(negedge clk);

    tbl.push_back('{mkLoad(2'b01, 1'b1, 32'h100, 5'd9), 32'h80010000, 0});
    tbl.push_back('{mkLoad(2'b00, 1'b0, 32'h204, 5'd10), 32'hDEADBEEF, 2});
    tbl.push_back('{mkLoad(2'b11, 1'b0, 32'h400, 5'd11), 32'h9A000000, 0});
    tbl.push_back('{mkStore(2'b00, 32'h500, 32'h12345678), 32'h0, 1});
    tbl.push_back('{mkLoad(2'b00, 1'b0, 32'h6, 5'd12), 32'hCAFEF00D, 0});
    tbl.push_back('{mkLoad(2'b01, 1'b1, 32'h103, 5'd13), 32'h0000FEDC, 1});
    tbl.push_back('{mkAlu(32'h5555AAAA, 5'd14, 2'b10), 32'h0, 0});
    foreach (tbl[i]) begin
      run(tbl[i].v, tbl[i].rd, tbl[i].dly, bc, fr, fa, fb, fw);
      @(negedge clk);
    end

    // Reset while a store waits for an ack that never comes.
    @(posedge clk); #1;
    drv = mkStore(2'b00, 32'h10, 32'h0BADF00D); ackDelay = 1000;
    @(posedge clk); #1;
    drv = '0;
    @(negedge clk);
    chk("pre_rst_busy", 32'(mem_busy), 32'h1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_req", 32'(dmem_req), 32'h0);
    chk("rst_busy", 32'(mem_busy), 32'h0);
    chk("rst_wb", 32'(wRegWr), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1; ackDelay = 0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
